// File: rtl/ysyx_25040105_pkg.sv
// Shared RV32I decode definitions: opcodes, ALU and jump codes,
// and the decoded-bundle layout passed from IDU to EXU.
package ysyx_25040105_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [31:0] INST_EBREAK = 32'h0010_0073;

    localparam logic [3:0] ALU_ADD   = 4'd0;
    localparam logic [3:0] ALU_SUB   = 4'd1;
    localparam logic [3:0] ALU_SLL   = 4'd2;
    localparam logic [3:0] ALU_SRL   = 4'd3;
    localparam logic [3:0] ALU_AUIPC = 4'd4;
    localparam logic [3:0] ALU_LUI   = 4'd5;
    localparam logic [3:0] ALU_SRA   = 4'd6;
    localparam logic [3:0] ALU_SLT   = 4'd7;
    localparam logic [3:0] ALU_SLTU  = 4'd8;
    localparam logic [3:0] ALU_XOR   = 4'd9;
    localparam logic [3:0] ALU_OR    = 4'd10;
    localparam logic [3:0] ALU_AND   = 4'd11;

    localparam logic [1:0] JUMP_NONE = 2'd0;
    localparam logic [1:0] JUMP_JAL  = 2'd1;
    localparam logic [1:0] JUMP_JALR = 2'd2;

    typedef struct packed {
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic [3:0]  alu_op;
        logic        alu_src;
        logic        reg_wen;
        logic        mem_ren;
        logic        mem_wen;
        logic [2:0]  mem_size;
        logic        branch;
        logic [1:0]  jump;
        logic        ebreak;
        logic        illegal;
    } dec_t;

    localparam int DEC_W = $bits(dec_t);

    // sub selects SUB for funct3 000, sra selects SRA for funct3 101
    function automatic logic [3:0] alu_of(
        input logic [2:0] f3,
        input logic       sub,
        input logic       sra
    );
        logic [3:0] op;
        case (f3)
            3'b000:  op = sub ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = sra ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/ysyx_25040105_idu_dec.sv
// Pure combinational RV32I decoder: instruction word -> dec_t bundle.
// Shared between the pipelined IDU and the single-cycle core.
module ysyx_25040105_idu_dec
    import ysyx_25040105_pkg::*;
(
    input  logic [31:0] inst,
    output dec_t        dec
);

    logic [6:0]  opcode;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_b;
    logic [31:0] imm_j;
    logic [31:0] imm_u;
    logic        legal;

    assign opcode = inst[6:0];
    assign f3     = inst[14:12];
    assign f7     = inst[31:25];

    assign imm_i = {{20{inst[31]}}, inst[31:20]};
    assign imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
    assign imm_b = {{19{inst[31]}}, inst[31], inst[7],
                    inst[30:25], inst[11:8], 1'b0};
    assign imm_j = {{11{inst[31]}}, inst[31], inst[19:12],
                    inst[20], inst[30:21], 1'b0};
    assign imm_u = {inst[31:12], 12'h000};

    always_comb begin
        dec        = '0;
        legal      = 1'b1;
        dec.rs1    = inst[19:15];
        dec.rs2    = inst[24:20];
        dec.rd     = inst[11:7];
        dec.alu_op = ALU_ADD;
        dec.ebreak = (inst == INST_EBREAK);

        unique case (1'b1)
            (opcode == OPC_LUI): begin
                dec.imm     = imm_u;
                dec.alu_op  = ALU_LUI;
                dec.alu_src = 1'b1;
                dec.reg_wen = 1'b1;
            end
            (opcode == OPC_AUIPC): begin
                dec.imm     = imm_u;
                dec.alu_op  = ALU_AUIPC;
                dec.alu_src = 1'b1;
                dec.reg_wen = 1'b1;
            end
            (opcode == OPC_JAL): begin
                dec.imm     = imm_j;
                dec.reg_wen = 1'b1;
                dec.jump    = JUMP_JAL;
            end
            (opcode == OPC_JALR): begin
                dec.imm     = imm_i;
                dec.alu_src = 1'b1;
                dec.reg_wen = 1'b1;
                dec.jump    = JUMP_JALR;
                legal       = (f3 == 3'b000);
            end
            (opcode == OPC_BRANCH): begin
                dec.imm      = imm_b;
                dec.branch   = 1'b1;
                dec.mem_size = f3;
                legal        = (f3 != 3'b010) && (f3 != 3'b011);
            end
            (opcode == OPC_LOAD): begin
                dec.imm      = imm_i;
                dec.alu_src  = 1'b1;
                dec.mem_ren  = 1'b1;
                dec.reg_wen  = 1'b1;
                dec.mem_size = f3;
                legal        = (f3 != 3'b011) && (f3[2:1] != 2'b11);
            end
            (opcode == OPC_STORE): begin
                dec.imm      = imm_s;
                dec.alu_src  = 1'b1;
                dec.mem_wen  = 1'b1;
                dec.mem_size = f3;
                legal        = !f3[2] && (f3 != 3'b011);
            end
            (opcode == OPC_OP_IMM): begin
                dec.imm     = imm_i;
                dec.alu_src = 1'b1;
                dec.reg_wen = 1'b1;
                dec.alu_op  = alu_of(f3, 1'b0, f7[5]);
                if (f3 == 3'b001) begin
                    legal = (f7 == 7'h00);
                end else if (f3 == 3'b101) begin
                    legal = (f7 == 7'h00) || (f7 == 7'h20);
                end
            end
            (opcode == OPC_OP): begin
                dec.reg_wen = 1'b1;
                dec.alu_op  = alu_of(f3, f7[5], f7[5]);
                // 0x20 only has a meaning for SUB and SRA
                legal = (f7 == 7'h00) ||
                        ((f7 == 7'h20) &&
                         ((f3 == 3'b000) || (f3 == 3'b101)));
            end
            (opcode == OPC_FENCE): begin
                legal = (f3 == 3'b000);
            end
            (opcode == OPC_SYSTEM): begin
                legal = (inst == INST_EBREAK);
            end
            default: begin
                legal = 1'b0;
            end
        endcase

        if (dec.rd == 5'd0) begin
            dec.reg_wen = 1'b0;
        end
        if (!legal) begin
            dec.reg_wen = 1'b0;
            dec.mem_ren = 1'b0;
            dec.mem_wen = 1'b0;
            dec.branch  = 1'b0;
            dec.jump    = JUMP_NONE;
        end
        dec.illegal = !legal;
    end

endmodule

// File: rtl/ysyx_25040105_idu_stage.sv
// Pipelined IDU: decodes on accept and buffers {pc, bundle} in a small
// FIFO so fetch continues while execute stalls.
module ysyx_25040105_idu_stage
    import ysyx_25040105_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int DEPTH    = 2,
    parameter int ALU_OP_W = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [XLEN-1:0]     in_pc,
    input  logic [31:0]         in_inst,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [XLEN-1:0]     out_pc,
    output logic [4:0]          out_rs1,
    output logic [4:0]          out_rs2,
    output logic [4:0]          out_rd,
    output logic [XLEN-1:0]     out_imm,
    output logic [ALU_OP_W-1:0] out_alu_op,
    output logic                out_alu_src,
    output logic                out_reg_wen,
    output logic                out_mem_ren,
    output logic                out_mem_wen,
    output logic [2:0]          out_mem_size,
    output logic                out_branch,
    output logic [1:0]          out_jump,
    output logic                out_ebreak,
    output logic                out_illegal
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    dec_t             in_dec;
    dec_t             head_dec;
    logic [XLEN-1:0]  head_pc;

    logic [XLEN-1:0]  pc_q  [DEPTH];
    logic [XLEN-1:0]  pc_d  [DEPTH];
    logic [DEC_W-1:0] dec_q [DEPTH];
    logic [DEC_W-1:0] dec_d [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] rd_ptr_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    logic [XLEN-1:0]  last_pc_q;
    logic [XLEN-1:0]  last_pc_d;
    logic [DEC_W-1:0] last_dec_q;
    logic [DEC_W-1:0] last_dec_d;

    logic             push;
    logic             pop;

    ysyx_25040105_idu_dec u_dec (
        .inst (in_inst),
        .dec  (in_dec)
    );

    function automatic logic [PTR_W-1:0] ptr_inc(
        input logic [PTR_W-1:0] p
    );
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign in_ready  = (cnt_q != CNT_W'(DEPTH));
    assign out_valid = (cnt_q != '0);
    assign push      = in_valid && in_ready && !flush;
    assign pop       = out_valid && out_ready && !flush;

    // When empty, keep showing whatever was last presented
    always_comb begin
        head_pc  = last_pc_q;
        head_dec = dec_t'(last_dec_q);
        if (out_valid) begin
            head_pc  = pc_q[rd_ptr_q];
            head_dec = dec_t'(dec_q[rd_ptr_q]);
        end
    end

    always_comb begin
        pc_d       = pc_q;
        dec_d      = dec_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        cnt_d      = cnt_q;
        last_pc_d  = head_pc;
        last_dec_d = head_dec;

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (push) begin
                pc_d[wr_ptr_q]  = in_pc;
                dec_d[wr_ptr_q] = in_dec;
                wr_ptr_d        = ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            case ({push, pop})
                2'b10:   cnt_d = cnt_q + CNT_W'(1);
                2'b01:   cnt_d = cnt_q - CNT_W'(1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                pc_q[i]  <= '0;
                dec_q[i] <= '0;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            last_pc_q  <= '0;
            last_dec_q <= '0;
        end else begin
            pc_q       <= pc_d;
            dec_q      <= dec_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            last_pc_q  <= last_pc_d;
            last_dec_q <= last_dec_d;
        end
    end

    assign out_pc       = head_pc;
    assign out_rs1      = head_dec.rs1;
    assign out_rs2      = head_dec.rs2;
    assign out_rd       = head_dec.rd;
    assign out_imm      = XLEN'(head_dec.imm);
    assign out_alu_op   = ALU_OP_W'(head_dec.alu_op);
    assign out_alu_src  = head_dec.alu_src;
    assign out_reg_wen  = head_dec.reg_wen;
    assign out_mem_ren  = head_dec.mem_ren;
    assign out_mem_wen  = head_dec.mem_wen;
    assign out_mem_size = head_dec.mem_size;
    assign out_branch   = head_dec.branch;
    assign out_jump     = head_dec.jump;
    assign out_ebreak   = head_dec.ebreak;
    assign out_illegal  = head_dec.illegal;

endmodule

// File: tb/tb_ysyx_25040105_idu_stage.sv
// Scoreboard bench for the pipelined IDU: driver queues expected bundles
// from a reference decoder, monitor pops and compares on each EXU accept.
module tb_ysyx_25040105_idu_stage;

    localparam int DEPTH = 2;

    typedef struct packed {
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic [3:0]  alu;
        logic        src;
        logic        wen;
        logic        ren;
        logic        mwen;
        logic [2:0]  msz;
        logic        br;
        logic [1:0]  jmp;
        logic        ebk;
        logic        ill;
    } bun_t;

    typedef struct packed {
        logic [31:0] pc;
        bun_t        b;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [31:0] in_inst;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [4:0]  out_rs1;
    logic [4:0]  out_rs2;
    logic [4:0]  out_rd;
    logic [31:0] out_imm;
    logic [3:0]  out_alu_op;
    logic        out_alu_src;
    logic        out_reg_wen;
    logic        out_mem_ren;
    logic        out_mem_wen;
    logic [2:0]  out_mem_size;
    logic        out_branch;
    logic [1:0]  out_jump;
    logic        out_ebreak;
    logic        out_illegal;

    int   n_chk = 0;
    int   n_err = 0;
    logic mon_en = 1'b0;
    ent_t exp_q[$];

    ysyx_25040105_idu_stage dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_pc        (in_pc),
        .in_inst      (in_inst),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_pc       (out_pc),
        .out_rs1      (out_rs1),
        .out_rs2      (out_rs2),
        .out_rd       (out_rd),
        .out_imm      (out_imm),
        .out_alu_op   (out_alu_op),
        .out_alu_src  (out_alu_src),
        .out_reg_wen  (out_reg_wen),
        .out_mem_ren  (out_mem_ren),
        .out_mem_wen  (out_mem_wen),
        .out_mem_size (out_mem_size),
        .out_branch   (out_branch),
        .out_jump     (out_jump),
        .out_ebreak   (out_ebreak),
        .out_illegal  (out_illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", nm, got, exp);
        end
    endtask

    // Reference decoder written straight from the instruction-set rules
    function automatic bun_t model(input logic [31:0] w);
        bun_t       b;
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        logic       ok;
        int         tbl[8];
        tbl = '{0, 2, 7, 8, 9, 3, 10, 11};
        op = w[6:0];
        f3 = w[14:12];
        f7 = w[31:25];
        b = '0;
        b.rs1 = w[19:15];
        b.rs2 = w[24:20];
        b.rd  = w[11:7];
        ok = 1'b1;
        case (op)
            7'h37: begin
                b.imm = {w[31:12], 12'h0}; b.alu = 4'd5;
                b.src = 1'b1; b.wen = 1'b1;
            end
            7'h17: begin
                b.imm = {w[31:12], 12'h0}; b.alu = 4'd4;
                b.src = 1'b1; b.wen = 1'b1;
            end
            7'h6f: begin
                b.imm = 32'($signed({w[31], w[19:12], w[20],
                                     w[30:21], 1'b0}));
                b.wen = 1'b1; b.jmp = 2'd1;
            end
            7'h67: begin
                b.imm = 32'($signed(w[31:20]));
                b.src = 1'b1; b.wen = 1'b1; b.jmp = 2'd2;
                ok = (f3 == 0);
            end
            7'h63: begin
                b.imm = 32'($signed({w[31], w[7], w[30:25],
                                     w[11:8], 1'b0}));
                b.br = 1'b1; b.msz = f3;
                ok = (f3 != 2) && (f3 != 3);
            end
            7'h03: begin
                b.imm = 32'($signed(w[31:20]));
                b.src = 1'b1; b.ren = 1'b1; b.wen = 1'b1; b.msz = f3;
                ok = (f3 == 0) || (f3 == 1) || (f3 == 2) ||
                     (f3 == 4) || (f3 == 5);
            end
            7'h23: begin
                b.imm = 32'($signed({w[31:25], w[11:7]}));
                b.src = 1'b1; b.mwen = 1'b1; b.msz = f3;
                ok = (f3 < 3);
            end
            7'h13: begin
                b.imm = 32'($signed(w[31:20]));
                b.src = 1'b1; b.wen = 1'b1;
                b.alu = 4'(tbl[f3]);
                if (f3 == 5 && f7[5]) b.alu = 4'd6;
                if (f3 == 1) ok = (f7 == 0);
                if (f3 == 5) ok = (f7 == 0) || (f7 == 7'h20);
            end
            7'h33: begin
                b.wen = 1'b1;
                b.alu = 4'(tbl[f3]);
                if (f3 == 0 && f7[5]) b.alu = 4'd1;
                if (f3 == 5 && f7[5]) b.alu = 4'd6;
                ok = (f7 == 0) ||
                     (f7 == 7'h20 && (f3 == 0 || f3 == 5));
            end
            7'h0f: ok = (f3 == 0);
            7'h73: ok = (w == 32'h0010_0073);
            default: ok = 1'b0;
        endcase
        b.ebk = (w == 32'h0010_0073);
        if (b.rd == 0) b.wen = 1'b0;
        b.ill = !ok;
        if (!ok) begin
            b.wen = 0; b.ren = 0; b.mwen = 0; b.br = 0; b.jmp = 0;
        end
        return b;
    endfunction

    function automatic logic [31:0] gen_inst();
        logic [6:0]  ops[11];
        logic [31:0] w;
        int          sel;
        ops = '{7'h37, 7'h17, 7'h6f, 7'h67, 7'h63, 7'h03,
                7'h23, 7'h13, 7'h33, 7'h0f, 7'h73};
        w = $urandom;
        sel = $urandom_range(0, 9);
        if (sel < 7) begin
            w[6:0] = ops[$urandom_range(0, 10)];
            if ($urandom_range(0, 1) == 1)
                w[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
            if ($urandom_range(0, 7) == 0) w[11:7] = 5'd0;
        end else if (sel == 7) begin
            w = 32'h0010_0073;
        end
        return w;
    endfunction

    // One clock of stimulus; entered and left 1 time unit after posedge
    task automatic cycle(input logic v, input logic [31:0] pc,
                         input logic [31:0] inst, input logic rdy,
                         input logic fl, output logic acc);
        in_valid  = v;
        in_pc     = pc;
        in_inst   = inst;
        out_ready = rdy;
        flush     = fl;
        @(negedge clk);
        acc = v && in_ready && !fl;
        @(posedge clk);
        if (acc) exp_q.push_back('{pc: pc, b: model(inst)});
        #1;
    endtask

    always @(negedge clk) begin
        if (mon_en && rst_n) begin
            ent_t e;
            bun_t a;
            chk("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
            chk("in_ready", 64'(in_ready), 64'(exp_q.size() < DEPTH));
            if (flush) begin
                exp_q.delete();
            end else if (out_valid && out_ready && exp_q.size() != 0) begin
                e = exp_q.pop_front();
                a = '{rs1: out_rs1, rs2: out_rs2, rd: out_rd,
                      imm: out_imm, alu: out_alu_op, src: out_alu_src,
                      wen: out_reg_wen, ren: out_mem_ren,
                      mwen: out_mem_wen, msz: out_mem_size,
                      br: out_branch, jmp: out_jump,
                      ebk: out_ebreak, ill: out_illegal};
                chk("out_pc", 64'(out_pc), 64'(e.pc));
                chk("bundle", 64'(a), 64'(e.b));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic        acc;
        logic [31:0] pc;
        rst_n = 1'b0; flush = 0; in_valid = 0; out_ready = 0;
        in_pc = 0; in_inst = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst out_valid", 64'(out_valid), 64'd0);
        chk("rst in_ready", 64'(in_ready), 64'd1);
        chk("rst out_pc", 64'(out_pc), 64'd0);
        chk("rst out_imm", 64'(out_imm), 64'd0);
        chk("rst out_alu_op", 64'(out_alu_op), 64'd0);
        chk("rst out_reg_wen", 64'(out_reg_wen), 64'd0);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        mon_en = 1'b1;

        // T1..T3: directed decode through the scoreboard
        cycle(1, 32'h100, 32'h0050_0093, 1, 0, acc);
        chk("t1 accept", 64'(acc), 64'd1);
        cycle(1, 32'h104, 32'h4020_81B3, 1, 0, acc);
        cycle(1, 32'h108, 32'h1234_52B7, 1, 0, acc);
        cycle(1, 32'h10c, 32'h0010_0073, 1, 0, acc);
        cycle(1, 32'h110, 32'hFFFF_FFFF, 1, 0, acc);
        cycle(1, 32'h114, 32'h0000_0013, 1, 0, acc);
        cycle(0, 0, 0, 1, 0, acc);
        chk("t3 drained", 64'(out_valid), 64'd0);

        // T4: fill with EXU stalled, then release
        cycle(1, 32'h0, 32'h0000_0013, 0, 0, acc);
        cycle(1, 32'h4, 32'h0000_0013, 0, 0, acc);
        chk("t4 full in_ready", 64'(in_ready), 64'd0);
        cycle(1, 32'h8, 32'h0000_0013, 0, 0, acc);
        chk("t4 third rejected", 64'(acc), 64'd0);
        cycle(0, 0, 0, 1, 0, acc);
        chk("t4 in_ready after pop", 64'(in_ready), 64'd1);
        chk("t4 head pc", 64'(out_pc), 64'h4);
        cycle(0, 0, 0, 1, 0, acc);

        // T5: flush with two buffered and a push in the same cycle
        cycle(1, 32'h20, 32'h0010_0093, 0, 0, acc);
        cycle(1, 32'h24, 32'h0020_0113, 0, 0, acc);
        cycle(1, 32'h28, 32'h0030_0193, 0, 1, acc);
        chk("t5 out_valid", 64'(out_valid), 64'd0);
        chk("t5 in_ready", 64'(in_ready), 64'd1);
        cycle(0, 0, 0, 1, 0, acc);
        chk("t5 input lost", 64'(out_valid), 64'd0);

        // T6: asynchronous reset between edges
        cycle(1, 32'h40, 32'h0050_0093, 0, 0, acc);
        #2 rst_n = 1'b0;
        #1;
        chk("t6 out_valid", 64'(out_valid), 64'd0);
        chk("t6 in_ready", 64'(in_ready), 64'd1);
        exp_q.delete();
        in_valid = 0; out_ready = 0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("t6 no stale", 64'(out_valid), 64'd0);
        cycle(1, 32'h44, 32'h0070_0393, 1, 0, acc);

        // Random traffic with stalls and occasional flushes
        pc = 32'h8000_0000;
        for (int k = 0; k < 500; k++) begin
            logic v;
            logic r;
            logic f;
            v = ($urandom_range(0, 2) != 0);
            r = ($urandom_range(0, 2) != 0);
            f = ($urandom_range(0, 39) == 0);
            cycle(v, pc, gen_inst(), r, f, acc);
            if (acc) pc = pc + 32'd4;
        end

        for (int k = 0; k < 20 && exp_q.size() != 0; k++)
            cycle(0, 0, 0, 1, 0, acc);
        chk("drain", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_chk, n_err);
        $finish;
    end

endmodule
